// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP48 MAC driver: OPMODE codes, FSM states and the issue tag.
`default_nettype none

package dsp_pkg;

  localparam int DSP_LAT_DEFAULT = 3;

  // X mux in bits [1:0] and Z mux in bits [3:2]; pre-adder, carry-in and subtract all off
  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;
  localparam logic [7:0] OPM_HOLD  = 8'h08;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  typedef struct packed {
    logic issue;
    logic first;
  } tag_t;

  function automatic logic [7:0] tag_to_opmode(input tag_t t);
    if (!t.issue) return OPM_HOLD;
    return t.first ? OPM_FIRST : OPM_ACC;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dsp_tag_pipe.sv
// Shift register of {issue, first} tags; tap i is the tag after i+1 register stages.
`default_nettype none

module dsp_tag_pipe
  import dsp_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int OPM_TAP = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  tag_t tag_in,
  output tag_t opm_tag,
  output tag_t win_tag
);

  tag_t [DEPTH-1:0] pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe <= '0;
    end else if (clr) begin
      pipe <= '0;
    end else begin
      pipe <= {pipe[DEPTH-2:0], tag_in};
    end
  end

  assign opm_tag = pipe[OPM_TAP-1];
  assign win_tag = pipe[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/dsp_mac_driver.sv
// Streams (a,b) beats into a DSP48 slice as a dot product and returns P, beat count and overflow.
`default_nettype none

module dsp_mac_driver
  import dsp_pkg::*;
#(
  parameter int DSP_LAT   = DSP_LAT_DEFAULT,
  parameter int OPM_DELAY = 1,
  parameter int CNT_W     = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [17:0]      s_a,
  input  logic [17:0]      s_b,
  input  logic             s_last,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  input  logic [47:0]      dsp_p,
  input  logic             dsp_cout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [47:0]      m_data,
  output logic [CNT_W-1:0] m_count,
  output logic             m_ovf
);

  localparam int WIN     = DSP_LAT + OPM_DELAY;
  localparam int DRAIN_W = $clog2(WIN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state, state_nx;
  logic               accept;
  tag_t               tag_in, opm_tag, win_tag;
  logic [CNT_W-1:0]   count;
  logic               ovf_acc;
  logic               ovf_nx;
  logic [DRAIN_W-1:0] drain;

  assign accept       = s_valid & s_ready;
  assign tag_in.issue = accept;
  assign tag_in.first = (state == ST_IDLE);
  assign ovf_nx       = ovf_acc | (win_tag.issue & dsp_cout);

  dsp_tag_pipe #(
    .DEPTH   (WIN),
    .OPM_TAP (OPM_DELAY)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .tag_in  (tag_in),
    .opm_tag (opm_tag),
    .win_tag (win_tag)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = s_last ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (accept && s_last) state_nx = ST_DRAIN;
      ST_DRAIN: if (drain == '0) state_nx = ST_OUT;
      ST_OUT:   if (m_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      s_ready <= 1'b0;
      dsp_a <= '0;
      dsp_b <= '0;
      dsp_opmode <= '0;
      dsp_ce <= 1'b0;
      count <= '0;
      ovf_acc <= 1'b0;
      drain <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_count <= '0;
      m_ovf <= 1'b0;
    end else if (clr) begin
      state <= ST_IDLE;
      s_ready <= 1'b0;
      dsp_a <= '0;
      dsp_b <= '0;
      dsp_opmode <= '0;
      dsp_ce <= 1'b0;
      count <= '0;
      ovf_acc <= 1'b0;
      drain <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_count <= '0;
      m_ovf <= 1'b0;
    end else begin
      state <= state_nx;
      dsp_ce <= 1'b1;
      // s_ready is registered so it reads 0 during reset, as every other output does
      s_ready <= (state_nx == ST_IDLE) || (state_nx == ST_RUN);
      dsp_opmode <= tag_to_opmode(opm_tag);

      if (accept) begin
        dsp_a <= s_a;
        dsp_b <= s_b;
        if (state == ST_IDLE) count <= {{(CNT_W-1){1'b0}}, 1'b1};
        else if (count != CNT_MAX) count <= count + 1'b1;
      end

      if (accept && state == ST_IDLE) ovf_acc <= 1'b0;
      else ovf_acc <= ovf_nx;

      if (state_nx == ST_DRAIN && state != ST_DRAIN) drain <= DRAIN_W'(WIN - 1);
      else if (state == ST_DRAIN) drain <= drain - 1'b1;

      // The last beat's sum and carry are on the slice outputs when the drain count hits 0
      if (state == ST_DRAIN && drain == '0) begin
        m_valid <= 1'b1;
        m_data <= dsp_p;
        m_count <= count;
        m_ovf <= ovf_nx;
      end else if (state == ST_OUT && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dsp_mac_driver.sv
// Bench for dsp_mac_driver with a behavioural DSP48A1 slice; results checked against a dot-product model.
`timescale 1ns/1ps
`default_nettype none

module tb_dsp_mac_driver;
  import dsp_pkg::*;

  localparam int CNT_W = 13;
  localparam int LAT   = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [17:0]      s_a = '0;
  logic [17:0]      s_b = '0;
  logic             s_last = 1'b0;
  logic [17:0]      dsp_a;
  logic [17:0]      dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_ce;
  logic [47:0]      dsp_p = '0;
  logic             dsp_cout = 1'b0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [47:0]      m_data;
  logic [CNT_W-1:0] m_count;
  logic             m_ovf;

  dsp_mac_driver #(.DSP_LAT(3), .OPM_DELAY(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce),
    .dsp_p(dsp_p), .dsp_cout(dsp_cout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_count(m_count), .m_ovf(m_ovf)
  );

  always #5 clk = ~clk;

  // DSP48A1 slice: A1REG, B1REG, MREG, OPMODEREG, PREG and CARRYOUTREG all enabled
  logic [17:0] a1 = '0, b1 = '0;
  logic [35:0] m_reg = '0;
  logic [7:0]  opm_r = '0;
  logic [47:0] xmux, zmux;

  always_comb begin
    xmux = '0;
    zmux = '0;
    case (opm_r[1:0])
      2'd1: xmux = {12'd0, m_reg};
      2'd2: xmux = dsp_p;
      default: xmux = '0;
    endcase
    if (opm_r[3:2] == 2'd2) zmux = dsp_p;
  end

  always @(posedge clk) begin
    if (dsp_ce) begin
      a1 <= dsp_a;
      b1 <= dsp_b;
      m_reg <= 36'(a1) * 36'(b1);
      opm_r <= dsp_opmode;
      {dsp_cout, dsp_p} <= {1'b0, xmux} + {1'b0, zmux};
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero_outs(input string tag);
    check({tag, "_ctl"}, {s_ready, dsp_a, dsp_b, dsp_opmode, dsp_ce, m_valid}, 64'd0);
    check({tag, "_data"}, m_data, 64'd0);
    check({tag, "_cnt"}, {m_count, m_ovf}, 64'd0);
  endtask

  logic [17:0] qa[$];
  logic [17:0] qb[$];
  int          qg[$];

  task automatic add_beat(input logic [17:0] a, input logic [17:0] b, input int gap);
    qa.push_back(a);
    qb.push_back(b);
    qg.push_back(gap);
  endtask

  // Sends the queued vector, then checks the result against the plain-arithmetic dot product
  task automatic run_vector(input string tag, input int hold);
    int n;
    int t;
    int accs[$];
    logic [63:0] prods[$];
    logic [63:0] sum;
    logic [63:0] psum;
    logic [63:0] exp_data;
    logic [63:0] exp_cnt;
    logic        exp_ovf;
    bit          any;
    n = qa.size();
    sum = 0;
    for (int i = 0; i < n; i++) sum += 64'(qa[i]) * 64'(qb[i]);
    exp_data = sum & 64'hFFFF_FFFF_FFFF;
    exp_ovf = (sum >= 64'h1_0000_0000_0000);
    exp_cnt = (n > 8191) ? 64'd8191 : 64'(n);

    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_a = qa[i];
      s_b = qb[i];
      s_last = (i == n - 1);
      t = 0;
      @(negedge clk);
      while (!s_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!s_ready) check({tag, "_accept_timeout"}, 0, 1);
      @(posedge clk);
      #1;
      accs.push_back(cyc);
      prods.push_back(64'(qa[i]) * 64'(qb[i]));
      s_valid = 1'b0;
      s_last = 1'b0;
      for (int g = 0; g < qg[i]; g++) begin
        @(posedge clk);
        #1;
        // P reflects every beat of this vector accepted at least three edges ago
        psum = 0;
        any = 0;
        for (int k = 0; k < accs.size(); k++) begin
          if (accs[k] <= cyc - 3) begin
            psum += prods[k];
            any = 1;
          end
        end
        if (any) check({tag, "_gap_p"}, dsp_p, psum & 64'hFFFF_FFFF_FFFF);
      end
    end

    t = 0;
    while (!m_valid && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check({tag, "_valid"}, m_valid, 1);
    check({tag, "_lat"}, 64'(cyc + 1 - accs[accs.size() - 1]), LAT);
    check({tag, "_data"}, m_data, exp_data);
    check({tag, "_count"}, m_count, exp_cnt);
    check({tag, "_ovf"}, m_ovf, exp_ovf);
    check({tag, "_sready_out"}, s_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold"}, {m_valid, s_ready, m_ovf, m_count, m_data},
            {1'b1, 1'b0, exp_ovf, exp_cnt[CNT_W-1:0], exp_data[47:0]});
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check({tag, "_drop"}, m_valid, 0);
    qa.delete();
    qb.delete();
    qg.delete();
  endtask

  task automatic abort_mid_vector(input string tag, input bit use_clr);
    int t;
    bit seen;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_a = 18'(10 + i);
      s_b = 18'(20 + i);
      s_last = 1'b0;
      t = 0;
      @(negedge clk);
      while (!s_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (i == 0) begin
        @(posedge clk);
        #1;
      end
    end
    // Beat 2 is on the bus when the vector is aborted
    if (use_clr) begin
      clr = 1'b1;
      @(posedge clk);
      #1;
      check_zero_outs(tag);
      clr = 1'b0;
    end else begin
      rst = 1'b1;
      #1;
      check_zero_outs(tag);
      @(negedge clk);
      rst = 1'b0;
    end
    s_valid = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (m_valid) seen = 1;
    end
    check({tag, "_no_mvalid"}, seen, 0);
  endtask

  initial begin
    #12;
    check_zero_outs("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("ce_after_reset", dsp_ce, 1);
    check("opm_idle", dsp_opmode, OPM_HOLD);
    check("sready_idle", s_ready, 1);

    add_beat(2, 3, 0); add_beat(4, 5, 0); add_beat(6, 7, 0);
    run_vector("t1_b2b", 0);

    add_beat(18'h3FFFF, 18'h3FFFF, 0);
    run_vector("t2_single", 0);

    add_beat(1, 1, 3); add_beat(2, 2, 1); add_beat(3, 3, 0);
    run_vector("t3_gaps", 0);

    add_beat(7, 8, 0); add_beat(1, 2, 0);
    run_vector("t4_backpressure", 6);
    add_beat(5, 5, 0);
    run_vector("t4_next", 0);

    abort_mid_vector("t5_rst", 1'b0);
    add_beat(9, 9, 0);
    run_vector("t5_after_rst", 0);

    abort_mid_vector("t5_clr", 1'b1);
    add_beat(9, 9, 1); add_beat(3, 4, 0);
    run_vector("t5_after_clr", 1);

    for (int v = 0; v < 20; v++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        logic [17:0] a, b;
        a = ($urandom_range(0, 3) == 0) ? 18'h3FFFF : 18'($urandom);
        b = 18'($urandom);
        add_beat(a, b, (i == len - 1 || $urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
      end
      run_vector($sformatf("rnd%0d", v), $urandom_range(0, 4));
    end

    for (int i = 0; i < 4097; i++) add_beat(18'h3FFFF, 18'h3FFFF, 0);
    run_vector("t6_ovf", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

endmodule

`default_nettype wire
